seq_checker: RTL and testbench

SEQ_CHECKER -- requirements
Module: seq_checker

---
 rtl/simon_pkg.sv | 19 +
 rtl/seq_ram.sv | 28 ++
 rtl/seq_checker.sv | 124 ++++++++++++
 tb/tb_seq_checker.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types for the Simon game: colour codes, sequence depth and checker states.
package simon_pkg;

   localparam int SEQ_DEPTH = 32;

   typedef enum logic [1:0] {
      RED    = 2'd0,
      GREEN  = 2'd1,
      BLUE   = 2'd2,
      YELLOW = 2'd3
   } colour_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PLAYER = 2'd1,
      ST_DONE   = 2'd2
   } chk_state_t;

endpackage

// File: rtl/seq_ram.sv
// Colour sequence store: one write port, two combinational read ports (compare, playback).
module seq_ram
   import simon_pkg::*;
#(
   parameter int DEPTH    = SEQ_DEPTH,
   parameter int COLOUR_W = 2
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [COLOUR_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0]   raddr_a,
   output logic [COLOUR_W-1:0]        rdata_a,
   input  logic [$clog2(DEPTH)-1:0]   raddr_b,
   output logic [COLOUR_W-1:0]        rdata_b
);

   logic [COLOUR_W-1:0] r_mem [DEPTH];

   // Contents are deliberately not reset; a new game simply overwrites them.
   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
   end

   assign rdata_a = r_mem[raddr_a];
   assign rdata_b = r_mem[raddr_b];

endmodule

// File: rtl/seq_checker.sv
// Stores the generated colour sequence and checks the player's button presses against it.
//  state     | meaning
//  ST_IDLE   | waiting for the player's turn; result/empty cleared
//  ST_PLAYER | comparing each button press with mem[cmp_ptr]
//  ST_DONE   | round decided; result/empty held until player_turn drops
module seq_checker
   import simon_pkg::*;
#(
   parameter int DEPTH    = SEQ_DEPTH,
   parameter int COLOUR_W = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       load_colour,
   input  logic [COLOUR_W-1:0]        colour_in,
   input  logic                       player_turn,
   input  logic [$clog2(DEPTH)-1:0]   check_round,
   input  logic                       btn_valid,
   input  logic [COLOUR_W-1:0]        btn_colour,
   input  logic [$clog2(DEPTH)-1:0]   play_idx,
   output logic [COLOUR_W-1:0]        play_colour,
   output logic                       result,
   output logic                       empty,
   output logic                       seq_full
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   chk_state_t          r_state;
   logic [CNT_W-1:0]    r_wr_cnt;
   logic [IDX_W-1:0]    r_cmp_ptr;
   logic                r_result;
   logic                r_empty;

   logic                w_full;
   logic                w_load;
   logic [COLOUR_W-1:0] w_cmp_colour;
   logic                w_mismatch;
   logic                w_last;

   assign w_full = (r_wr_cnt == CNT_W'(DEPTH));
   assign w_load = load_colour && !start && !w_full;

   seq_ram #(
      .DEPTH    (DEPTH),
      .COLOUR_W (COLOUR_W)
   ) u_seq_ram (
      .clk      (clk),
      .we       (w_load),
      .waddr    (r_wr_cnt[IDX_W-1:0]),
      .wdata    (colour_in),
      .raddr_a  (r_cmp_ptr),
      .rdata_a  (w_cmp_colour),
      .raddr_b  (play_idx),
      .rdata_b  (play_colour)
   );

   // Reads see pre-write memory and pre-increment wr_cnt when a load coincides.
   assign w_mismatch = (w_cmp_colour != btn_colour) || ({1'b0, r_cmp_ptr} >= r_wr_cnt);
   assign w_last     = (r_cmp_ptr == check_round);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_wr_cnt  <= '0;
         r_cmp_ptr <= '0;
         r_result  <= 1'b0;
         r_empty   <= 1'b0;
      end else if (start) begin
         r_state   <= ST_IDLE;
         r_wr_cnt  <= '0;
         r_cmp_ptr <= '0;
         r_result  <= 1'b0;
         r_empty   <= 1'b0;
      end else begin
         if (w_load) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
         case (r_state)
            ST_IDLE: begin
               if (player_turn) begin
                  r_state   <= ST_PLAYER;
                  r_cmp_ptr <= '0;
                  r_result  <= 1'b0;
                  r_empty   <= 1'b0;
               end
            end
            ST_PLAYER: begin
               if (!player_turn) begin
                  r_state   <= ST_IDLE;
                  r_cmp_ptr <= '0;
                  r_result  <= 1'b0;
                  r_empty   <= 1'b0;
               end else if (btn_valid) begin
                  if (w_mismatch) begin
                     r_state  <= ST_DONE;
                     r_result <= 1'b0;
                     r_empty  <= 1'b1;
                  end else if (w_last) begin
                     r_state  <= ST_DONE;
                     r_result <= 1'b1;
                     r_empty  <= 1'b1;
                  end else begin
                     r_cmp_ptr <= r_cmp_ptr + IDX_W'(1);
                  end
               end
            end
            ST_DONE: begin
               if (!player_turn) begin
                  r_state  <= ST_IDLE;
                  r_result <= 1'b0;
                  r_empty  <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign result   = r_result;
   assign empty    = r_empty;
   assign seq_full = w_full;

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker with hand-computed expected values.
module tb_seq_checker;
   import simon_pkg::*;

   logic       clk;
   logic       rst;
   logic       start;
   logic       load_colour;
   logic [1:0] colour_in;
   logic       player_turn;
   logic [4:0] check_round;
   logic       btn_valid;
   logic [1:0] btn_colour;
   logic [4:0] play_idx;
   logic [1:0] play_colour;
   logic       result;
   logic       empty;
   logic       seq_full;

   int total = 0;
   int bad   = 0;

   seq_checker #(.DEPTH(32), .COLOUR_W(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .load_colour (load_colour),
      .colour_in   (colour_in),
      .player_turn (player_turn),
      .check_round (check_round),
      .btn_valid   (btn_valid),
      .btn_colour  (btn_colour),
      .play_idx    (play_idx),
      .play_colour (play_colour),
      .result      (result),
      .empty       (empty),
      .seq_full    (seq_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic load(input logic [1:0] c);
      load_colour = 1'b1;
      colour_in   = c;
      tick();
      load_colour = 1'b0;
   endtask

   task automatic press(input logic [1:0] c);
      btn_valid  = 1'b1;
      btn_colour = c;
      tick();
      btn_valid  = 1'b0;
   endtask

   task automatic peek(input string tag, input logic [4:0] idx, input logic [1:0] exp);
      play_idx = idx;
      #1;
      chk(tag, 8'(play_colour), 8'(exp));
   endtask

   task automatic end_turn();
      player_turn = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; load_colour = 1'b0; colour_in = '0;
      player_turn = 1'b0; check_round = '0; btn_valid = 1'b0;
      btn_colour = '0; play_idx = '0;
      tick(); tick();
      chk("rst_empty", 8'(empty), 8'd0);
      chk("rst_result", 8'(result), 8'd0);
      chk("rst_full", 8'(seq_full), 8'd0);
      rst = 1'b0;
      tick();

      // Full three-colour round passes
      do_start();
      load(RED); load(GREEN); load(BLUE);
      peek("play0", 5'd0, RED);
      peek("play2", 5'd2, BLUE);
      player_turn = 1'b1; check_round = 5'd2;
      tick();
      press(RED);
      press(GREEN);
      chk("pass_mid_empty", 8'(empty), 8'd0);
      press(BLUE);
      chk("pass_empty", 8'(empty), 8'd1);
      chk("pass_result", 8'(result), 8'd1);
      tick();
      chk("pass_hold", 8'(empty), 8'd1);
      end_turn();
      chk("pass_clr_empty", 8'(empty), 8'd0);
      chk("pass_clr_result", 8'(result), 8'd0);

      // Wrong colour fails; extra press ignored
      do_start();
      load(RED); load(GREEN);
      player_turn = 1'b1; check_round = 5'd1;
      tick();
      press(RED);
      press(BLUE);
      chk("fail_empty", 8'(empty), 8'd1);
      chk("fail_result", 8'(result), 8'd0);
      press(GREEN);
      chk("fail_extra_empty", 8'(empty), 8'd1);
      chk("fail_extra_result", 8'(result), 8'd0);
      end_turn();

      // Button outside PLAYER is ignored
      press(RED);
      chk("idle_btn", 8'(empty), 8'd0);

      // Abort mid-round restarts compare at index 0
      player_turn = 1'b1;
      tick();
      press(RED);
      end_turn();
      chk("abort_empty", 8'(empty), 8'd0);
      player_turn = 1'b1;
      tick();
      press(RED);
      press(GREEN);
      chk("abort_rerun_res", 8'(result), 8'd1);
      chk("abort_rerun_emp", 8'(empty), 8'd1);
      end_turn();

      // Fill the memory and try one more
      do_start();
      for (int i = 0; i < 31; i++) load(2'(i));
      chk("full_at31", 8'(seq_full), 8'd0);
      load(2'(31));
      chk("full_at32", 8'(seq_full), 8'd1);
      load(YELLOW);
      chk("full_at33", 8'(seq_full), 8'd1);
      peek("full_play31", 5'd31, YELLOW);
      peek("full_play0", 5'd0, RED);
      peek("full_play17", 5'd17, GREEN);
      // Async reset clears seq_full before any clock edge
      #2 rst = 1'b1;
      #1 chk("async_full", 8'(seq_full), 8'd0);
      rst = 1'b0;
      tick();

      // Compare beyond stored length fails (mem[1] still GREEN from fill)
      do_start();
      load(GREEN);
      player_turn = 1'b1; check_round = 5'd3;
      tick();
      press(GREEN);
      chk("short_mid_empty", 8'(empty), 8'd0);
      press(GREEN);
      chk("short_empty", 8'(empty), 8'd1);
      chk("short_result", 8'(result), 8'd0);
      end_turn();

      // Same-cycle load and press at cmp_ptr==wr_cnt uses pre-write state
      do_start();
      load(RED);
      player_turn = 1'b1; check_round = 5'd1;
      tick();
      press(RED);
      load_colour = 1'b1; colour_in = BLUE;
      btn_valid = 1'b1; btn_colour = BLUE;
      tick();
      load_colour = 1'b0; btn_valid = 1'b0;
      chk("coll_empty", 8'(empty), 8'd1);
      chk("coll_result", 8'(result), 8'd0);
      peek("coll_written", 5'd1, BLUE);
      load(YELLOW);
      peek("coll_next_idx", 5'd2, YELLOW);
      end_turn();

      // Reset mid-round after two correct presses
      do_start();
      load(RED); load(GREEN); load(BLUE);
      player_turn = 1'b1; check_round = 5'd2;
      tick();
      press(RED);
      press(GREEN);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_empty", 8'(empty), 8'd0);
      chk("rst_mid_result", 8'(result), 8'd0);
      chk("rst_mid_full", 8'(seq_full), 8'd0);
      rst = 1'b0;
      tick();
      press(BLUE);
      chk("rst_mid_fresh_emp", 8'(empty), 8'd1);
      chk("rst_mid_fresh_res", 8'(result), 8'd0);
      end_turn();
      load(YELLOW);
      peek("rst_mid_wr0", 5'd0, YELLOW);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
